// File: rtl/input_cond_pkg.sv
// Shared defaults and PIO word field positions for the input conditioner.
package input_cond_pkg;
   localparam int DEBOUNCE_CYCLES_DEF = 50000;
   localparam int N_KEYS_DEF          = 4;
   localparam int N_SW_DEF            = 18;
   localparam int WORD_W              = 32;
   // push_buttons_word layout: stable keys in [3:0], sticky press flags in [7:4]
   localparam int PB_STABLE_LSB       = 0;
   localparam int PB_STICKY_LSB       = 4;
   localparam int PB_FIELD_W          = 4;
endpackage

// File: rtl/debounce_bit.sv
// One input channel: 2-flop synchronizer, optional inversion, counter-based debounce.
module debounce_bit
   import input_cond_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter logic INIT            = 1'b0,
   parameter logic INVERT          = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic stable,
   output logic rise
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic             level;
   logic             done;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= INIT;
         sync_p1 <= INIT;
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
      end
   end

   // Synchronized sample in the active-high domain used by all downstream logic
   assign level = sync_p1 ^ INVERT;
   assign done  = (level != stable) && (cnt == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         stable <= 1'b0;
         rise   <= 1'b0;
      end else begin
         rise <= done & level;
         if (level == stable) begin
            cnt <= '0;
         end else if (done) begin
            stable <= level;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end
endmodule

// File: rtl/input_conditioner.sv
// Debounces push buttons and slide switches, produces press pulses and sticky press flags.
module input_conditioner
   import input_cond_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int N_KEYS          = N_KEYS_DEF,
   parameter int N_SW            = N_SW_DEF
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [N_KEYS-1:0] key_n,
   input  logic [N_SW-1:0]   sw,
   input  logic [N_KEYS-1:0] press_clear,
   output logic [31:0]       push_buttons_word,
   output logic [31:0]       switches_word,
   output logic [N_KEYS-1:0] press_pulse
);
   logic [N_KEYS-1:0] stable_keys;
   logic [N_KEYS-1:0] sticky;
   logic [N_SW-1:0]   stable_sw;
   logic [N_SW-1:0]   sw_rise_unused;

   // Keys reset to released (raw 1) and are inverted so 1 = pressed downstream
   for (genvar i = 0; i < N_KEYS; i++) begin : g_key
      debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .INIT(1'b1),
         .INVERT(1'b1)
      ) u_db (
         .clk(clk_clk),
         .rst_n(reset_reset_n),
         .raw(key_n[i]),
         .stable(stable_keys[i]),
         .rise(press_pulse[i])
      );
   end

   for (genvar i = 0; i < N_SW; i++) begin : g_sw
      debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .INIT(1'b0),
         .INVERT(1'b0)
      ) u_db (
         .clk(clk_clk),
         .rst_n(reset_reset_n),
         .raw(sw[i]),
         .stable(stable_sw[i]),
         .rise(sw_rise_unused[i])
      );
   end

   // A press arriving together with a clear keeps the flag set
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sticky <= '0;
      end else begin
         sticky <= press_pulse | (sticky & ~press_clear);
      end
   end

   always_comb begin
      push_buttons_word = '0;
      push_buttons_word[PB_STABLE_LSB +: N_KEYS] = stable_keys;
      push_buttons_word[PB_STICKY_LSB +: N_KEYS] = sticky;
      switches_word = '0;
      switches_word[N_SW-1:0] = stable_sw;
   end
endmodule

// File: tb/tb_input_conditioner.sv
// Directed and randomized bench for input_conditioner with a cycle-level behavioural model.
module tb_input_conditioner;
   localparam int DC = 8;
   localparam int NK = 4;
   localparam int NS = 18;
   localparam int NC = NK + NS;
   localparam logic [NC-1:0] INV = {{NS{1'b0}}, {NK{1'b1}}};

   logic          clk_clk = 1'b0;
   logic          reset_reset_n = 1'b0;
   logic [NK-1:0] key_n = '1;
   logic [NS-1:0] sw = '0;
   logic [NK-1:0] press_clear = '0;
   logic [31:0]   push_buttons_word;
   logic [31:0]   switches_word;
   logic [NK-1:0] press_pulse;

   int checks = 0;
   int failures = 0;

   // Model state: raw samples two edges deep, debounced level per channel, run lengths
   logic [NC-1:0] m_s1 = INV;
   logic [NC-1:0] m_s2 = INV;
   logic [NC-1:0] m_stable = '0;
   logic [NK-1:0] m_pulse = '0;
   logic [NK-1:0] m_sticky = '0;
   int            run [NC];

   input_conditioner #(.DEBOUNCE_CYCLES(DC), .N_KEYS(NK), .N_SW(NS)) dut (
      .clk_clk(clk_clk),
      .reset_reset_n(reset_reset_n),
      .key_n(key_n),
      .sw(sw),
      .press_clear(press_clear),
      .push_buttons_word(push_buttons_word),
      .switches_word(switches_word),
      .press_pulse(press_pulse)
   );

   always #5 clk_clk = ~clk_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
      checks++;
      assert (obs >= lo && obs <= hi) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
      end
   endtask

   // A level must differ from the debounced value for DC consecutive edges to be adopted
   task automatic model_edge();
      logic [NC-1:0] lvl;
      logic [NC-1:0] old_stable;
      if (!reset_reset_n) begin
         m_s1 = INV;
         m_s2 = INV;
         m_stable = '0;
         m_pulse = '0;
         m_sticky = '0;
         foreach (run[i]) run[i] = 0;
         return;
      end
      lvl = m_s2 ^ INV;
      old_stable = m_stable;
      for (int i = 0; i < NC; i++) begin
         if (lvl[i] != m_stable[i]) begin
            run[i] = run[i] + 1;
            if (run[i] == DC) begin
               m_stable[i] = lvl[i];
               run[i] = 0;
            end
         end else begin
            run[i] = 0;
         end
      end
      m_sticky = m_pulse | (m_sticky & ~press_clear);
      m_pulse = m_stable[NK-1:0] & ~old_stable[NK-1:0];
      m_s2 = m_s1;
      m_s1 = {sw, key_n};
   endtask

   task automatic step();
      @(posedge clk_clk);
      model_edge();
      #1;
      chk("push_buttons_word", push_buttons_word, {24'b0, m_sticky, m_stable[NK-1:0]});
      chk("switches_word", switches_word, {14'b0, m_stable[NC-1:NK]});
      chk("press_pulse", {28'b0, press_pulse}, {28'b0, m_pulse});
   endtask

   initial begin
      int first;
      int pulses;
      int found;
      logic held;
      foreach (run[i]) run[i] = 0;

      // Reset and idle
      repeat (3) step();
      chk("reset_pb_word", push_buttons_word, 32'h0);
      chk("reset_sw_word", switches_word, 32'h0);
      reset_reset_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 100; k++) begin
         step();
         if (press_pulse != '0) pulses++;
      end
      chk("idle_pb_word", push_buttons_word, 32'h0);
      chk("idle_pulses", pulses, 0);

      // Single press of key 0
      key_n[0] = 1'b0;
      first = -1;
      pulses = 0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (first < 0 && push_buttons_word == 32'h11) first = k;
         if (press_pulse[0]) pulses++;
      end
      chk_range("press_word_latency", first, 9, 11);
      chk("press0_pulse_count", pulses, 1);
      key_n[0] = 1'b1;
      repeat (15) step();
      chk("after_release_word", push_buttons_word, 32'h10);

      // Short glitches on key 1
      pulses = 0;
      for (int r = 0; r < 4; r++) begin
         key_n[1] = 1'b0;
         for (int k = 0; k < 5; k++) begin step(); if (press_pulse != '0) pulses++; end
         key_n[1] = 1'b1;
         for (int k = 0; k < 5; k++) begin step(); if (press_pulse != '0) pulses++; end
      end
      chk("glitch_word", push_buttons_word, 32'h10);
      chk("glitch_pulses", pulses, 0);

      // Clear coincident with a new press keeps the flag; a lone clear drops it
      key_n[0] = 1'b0;
      found = 0;
      for (int k = 0; k < 30 && found == 0; k++) begin
         step();
         if (press_pulse[0]) found = 1;
      end
      chk("press0_again_seen", found, 1);
      press_clear[0] = 1'b1;
      step();
      press_clear[0] = 1'b0;
      chk("sticky_set_wins", {31'b0, push_buttons_word[4]}, 32'h1);
      key_n[0] = 1'b1;
      repeat (15) step();
      press_clear[0] = 1'b1;
      step();
      press_clear[0] = 1'b0;
      chk("sticky_lone_clear", {31'b0, push_buttons_word[4]}, 32'h0);

      // Switches
      sw = '1;
      repeat (12) step();
      chk("sw_all_on", switches_word, 32'h0003FFFF);
      held = 1'b1;
      for (int k = 0; k < 30; k++) begin
         if (k % 3 == 0) sw[17] = ~sw[17];
         step();
         held = held & switches_word[17];
      end
      chk("sw17_holds", {31'b0, held}, 32'h1);
      sw = '0;
      repeat (15) step();
      chk("sw_all_off", switches_word, 32'h0);

      // Reset mid-debounce of key 2
      key_n[2] = 1'b0;
      repeat (7) step();
      reset_reset_n = 1'b0;
      repeat (2) step();
      chk("midreset_pb_word", push_buttons_word, 32'h0);
      reset_reset_n = 1'b1;
      first = -1;
      pulses = 0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (press_pulse[2]) begin
            pulses++;
            if (first < 0) first = k;
         end
      end
      chk("redebounce_pulse_count", pulses, 1);
      chk("redebounce_pulse_cycle", first, 10);

      // Randomized traffic with occasional resets
      for (int k = 0; k < 1500; k++) begin
         for (int i = 0; i < NK; i++)
            if ($urandom_range(0, 11) == 0) key_n[i] = ~key_n[i];
         for (int i = 0; i < NS; i++)
            if ($urandom_range(0, 15) == 0) sw[i] = ~sw[i];
         for (int i = 0; i < NK; i++)
            press_clear[i] = ($urandom_range(0, 5) == 0);
         reset_reset_n = ($urandom_range(0, 249) != 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
